// File: rtl/mux_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_arbiter_pkg
// Shared types for the two-input round-robin arbiter.
//   state_t : output stage state (EMPTY = nothing held, FULL = out holds a word)
//   grant_t : requester index (GRANT_A = 0, GRANT_B = 1); also the encoding
//             of out_sel and of the mux select line.
//   pick_grant : chooses the winner among the valid requesters.
// Optional feature macro used by the top: MUX_ARBITER_STATS_EN.
// -----------------------------------------------------------------------------
package mux_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // Single requester wins outright; on contention the requester that did
    // NOT win last time gets the grant. Result is only meaningful when at
    // least one requester is valid.
    function automatic grant_t pick_grant(
        input logic   a_valid,
        input logic   b_valid,
        input grant_t last
    );
        grant_t g;
        if (a_valid && b_valid) begin
            g = (last == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (b_valid) begin
            g = GRANT_B;
        end else begin
            g = GRANT_A;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// -----------------------------------------------------------------------------
// mux_arbiter_mux
// Purely combinational 2:1 data multiplexer used as the arbiter datapath.
// Ports:
//   a, b : WIDTH-bit data inputs
//   sel  : 0 selects a, 1 selects b (same encoding as grant_t)
//   y    : WIDTH-bit selected data
// -----------------------------------------------------------------------------
module mux_arbiter_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        if (sel) begin
            y = b;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
// Two-requester round-robin arbiter with a single registered output stage.
// A word is accepted from the winning requester whenever the output stage is
// empty or is being drained in the same cycle, giving one word per cycle
// throughput with 1-cycle latency.
//
// Ports:
//   clk                    : sole clock, rising edge
//   rst                    : synchronous active-high reset
//   in_a, in_b             : requester data (WIDTH)
//   in_a_valid, in_b_valid : requester offers data
//   in_a_ready, in_b_ready : requester's word is taken this cycle (comb.)
//   out                    : registered winning data (WIDTH)
//   out_valid              : out holds a word
//   out_ready              : consumer takes out this cycle
//   out_sel                : source of out, 0 = A, 1 = B
//   grant_cnt_a/_b         : saturating grant counters (CNT_W), only present
//                            when MUX_ARBITER_STATS_EN is defined
//
// Configuration macro: MUX_ARBITER_STATS_EN
// -----------------------------------------------------------------------------
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic             in_a_valid,
    output logic             in_a_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_b_valid,
    output logic             in_b_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MUX_ARBITER_STATS_EN
    output logic             out_sel,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b
`else
    output logic             out_sel
`endif
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    grant_t           sel_reg, sel_next;
    grant_t           last_grant_reg, last_grant_next;

    grant_t           grant;
    logic             load;
    logic [WIDTH-1:0] mux_y;

    // Current-cycle winner; drives the datapath select directly so the
    // captured word and the reported out_sel always agree.
    assign grant = pick_grant(in_a_valid, in_b_valid, last_grant_reg);

    mux_arbiter_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (in_a),
        .b   (in_b),
        .sel (grant),
        .y   (mux_y)
    );

    // Accept a word only if the output register is free now or is being
    // drained this cycle. Reset suppresses acceptance so no requester sees
    // a handshake for a word that the reset is about to discard.
    assign load = (in_a_valid || in_b_valid)
               && ((state_reg == EMPTY) || out_ready)
               && !rst;

    always_comb begin
        in_a_ready = 1'b0;
        in_b_ready = 1'b0;
        if (load) begin
            in_a_ready = (grant == GRANT_A);
            in_b_ready = (grant == GRANT_B);
        end
    end

    always_comb begin
        state_next      = state_reg;
        out_next        = out_reg;
        sel_next        = sel_reg;
        last_grant_next = last_grant_reg;

        case (state_reg)
            EMPTY: begin
                if (load) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase

        if (load) begin
            out_next        = mux_y;
            sel_next        = grant;
            last_grant_next = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            out_reg        <= '0;
            sel_reg        <= GRANT_A;
            // Recording B as the last winner makes A win the first contention.
            last_grant_reg <= GRANT_B;
        end else begin
            state_reg      <= state_next;
            out_reg        <= out_next;
            sel_reg        <= sel_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = (state_reg == FULL);
    assign out_sel   = sel_reg;

`ifdef MUX_ARBITER_STATS_EN
    // One saturating counter per requester; index gi matches grant_t.
    logic [CNT_W-1:0] cnt_reg  [2];
    logic [CNT_W-1:0] cnt_next [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (load && (grant == grant_t'(gi)) && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                cnt_next[gi] = cnt_reg[gi] + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else begin
                cnt_reg[gi] <= cnt_next[gi];
            end
        end
    end

    assign grant_cnt_a = cnt_reg[0];
    assign grant_cnt_b = cnt_reg[1];
`endif

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each requester and the output.
REQ-002 SHALL have parameter CNT_W, default 16, width of the grant statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_a and in_b  input  WIDTH  requester A and B data.
REQ-006 SHALL have ports in_a_valid and in_b_valid  input  1  requester A and B offer data.
REQ-007 SHALL have ports in_a_ready and in_b_ready  output  1  requester A and B data accepted this cycle.
REQ-008 SHALL have port out  output  WIDTH  registered winning data.
REQ-009 SHALL have port out_valid  output  1  out holds a word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out.
REQ-011 SHALL have port out_sel  output  1  source of out: 0 = A, 1 = B.

Function
REQ-012 SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load = in_a_valid | in_b_valid, gated by (state==EMPTY) | out_ready.
REQ-014 SHALL, on load with one requester valid, grant that requester.
REQ-015 SHALL, on load with both valid, grant the requester not recorded in last_grant (round-robin).
REQ-016 SHALL assert in_x_ready combinationally, in the load cycle only, for the granted requester; the other ready SHALL be 0.
REQ-017 SHALL, on load, capture the granted data into out and its index into out_sel and last_grant at the next edge; latency is 1 cycle.
REQ-018 SHALL transition EMPTY->FULL on load; FULL->EMPTY on out_ready without load; FULL->FULL on out_ready with load (back-to-back, one word per cycle).
REQ-019 SHALL hold out, out_sel and last_grant stable while FULL and out_ready=0; both readies SHALL be 0.
REQ-020 SHALL never drop or duplicate a word: each ready-high cycle transfers exactly one word.
REQ-021 SHALL ignore in_x data when in_x_valid=0.

Reset
REQ-022 SHALL, on rst high at a clock edge, force state=EMPTY, out_valid=0, out=0, out_sel=0, last_grant=B (A wins the first contention).
REQ-023 SHALL, with rst high, drive in_a_ready=0 and in_b_ready=0 and discard any word in FULL (reset mid-transfer drops it).

Configuration
REQ-024 SHALL support macro MUX_ARBITER_STATS_EN.
REQ-025 SHALL, with MUX_ARBITER_STATS_EN defined, add output ports grant_cnt_a and grant_cnt_b (CNT_W each), incrementing on each A or B grant, saturating at all-ones, cleared by rst.
REQ-026 SHALL, without the macro, omit those ports and counters entirely; the remaining behaviour is identical.

Structure
REQ-027 SHALL place the FSM state enum (EMPTY, FULL) and the grant enum (GRANT_A=0, GRANT_B=1) in shared package mux_arbiter_pkg.
REQ-028 SHALL instantiate the existing MUX module as the datapath sub-module, with sel driven by the current-cycle grant.

Verification
REQ-029 SHALL cover: reset, then only A valid with in_a=0x3C and out_ready=1 -> in_a_ready=1 same cycle; next cycle out=0x3C, out_sel=0, out_valid=1.
REQ-030 SHALL cover: both valid for 4 cycles with out_ready=1, in_a=0x11, in_b=0x22 -> out sequence 0x11, 0x22, 0x11, 0x22; out_sel 0, 1, 0, 1.
REQ-031 SHALL cover: out_ready=0 for 3 cycles while FULL with out=0x55 -> out stays 0x55, both readies 0; then out_ready=1 -> one transfer.
REQ-032 SHALL cover: rst asserted while FULL -> next cycle out_valid=0, out=0; first contention afterwards grants A.
REQ-033 SHALL cover: alternating A-only and B-only offers, 1 per cycle, out_ready=1 -> no bubbles and no drops; output order equals input order.
REQ-034 SHALL cover, with MUX_ARBITER_STATS_EN and CNT_W=2: 5 A grants -> grant_cnt_a=3, which saturates and holds; grant_cnt_b=0.
